// File: rtl/excp_redirect_pkg.sv
`default_nettype none
// ============================================================================
// excp_redirect_pkg : shared types for the exception/eret redirect path
// Revision: 1.0
// ============================================================================
package excp_redirect_pkg;

   localparam int REDIRECT_PC_W = 32;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } redirect_state_t;

   typedef enum logic {
      RK_EXC  = 1'b0,
      RK_ERET = 1'b1
   } redirect_kind_t;

   // Bundle handed to the fetch stage; layout {pc, kind}.
   typedef struct packed {
      logic [REDIRECT_PC_W-1:0] pc;
      redirect_kind_t           kind;
   } redirect_req_t;

   function automatic redirect_req_t pack_redirect(input logic [REDIRECT_PC_W-1:0] pc,
                                                   input redirect_kind_t kind);
      redirect_req_t r;
      r.pc   = pc;
      r.kind = kind;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/excp_redirect_sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : saturating event counter with increment enable
// Revision: 1.0
// ============================================================================
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] value;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         value <= '0;
      end else if (inc && (value != {WIDTH{1'b1}})) begin
         value <= value + 1'b1;
      end
   end

   assign count = value;

endmodule
`default_nettype wire

// File: rtl/excp_redirect.sv
`default_nettype none
// ============================================================================
// excp_redirect : holds one CP0 exception/eret redirect toward fetch
// Optional statistics counters enabled by EXCP_REDIRECT_STAT_EN.
// Revision: 1.0
// ============================================================================
module excp_redirect
   import excp_redirect_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              is_intexc,
   input  logic [ADDR_W-1:0] entrance,
   input  logic              is_eret,
   input  logic [ADDR_W-1:0] epc,
   input  logic              fetch_ready,
   output logic              redirect_valid,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic              redirect_kind,
   output logic              flush,
`ifdef EXCP_REDIRECT_STAT_EN
   output logic [31:0]       exc_cnt,
   output logic [31:0]       eret_cnt,
`endif
   output logic              commit_block
);

   redirect_state_t   state, next_state;
   logic [ADDR_W-1:0] req_pc;
   redirect_kind_t    req_kind;

   logic              req;
   logic              load;
   logic [ADDR_W-1:0] new_pc;
   redirect_kind_t    new_kind;
   logic              pending;
   logic              accept;

   assign req      = is_intexc | is_eret;
   // Exception has priority: a simultaneous eret is dropped.
   assign new_pc   = is_intexc ? entrance : epc;
   assign new_kind = is_intexc ? RK_EXC : RK_ERET;
   assign pending  = (state == PEND);
   assign accept   = pending & fetch_ready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         req_pc   <= '0;
         req_kind <= RK_EXC;
      end else begin
         state <= next_state;
         if (load) begin
            req_pc   <= new_pc;
            req_kind <= new_kind;
         end
      end
   end

   always_comb begin
      next_state = state;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               load       = 1'b1;
               next_state = PEND;
            end
         end
         PEND: begin
            // Only a new exception may replace or chain after a pending request.
            if (is_intexc) begin
               load       = 1'b1;
               next_state = PEND;
            end else if (fetch_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign redirect_valid = pending;
   assign commit_block   = pending;
   assign flush          = req | pending;
   assign redirect_pc    = req_pc;
   assign redirect_kind  = req_kind;

`ifdef EXCP_REDIRECT_STAT_EN
   logic exc_inc;
   logic eret_inc;

   assign exc_inc  = accept & (req_kind == RK_EXC);
   assign eret_inc = accept & (req_kind == RK_ERET);

   sat_counter #(.WIDTH(32)) u_exc_cnt (
      .clk    (clk),
      .resetn (resetn),
      .inc    (exc_inc),
      .count  (exc_cnt)
   );

   sat_counter #(.WIDTH(32)) u_eret_cnt (
      .clk    (clk),
      .resetn (resetn),
      .inc    (eret_inc),
      .count  (eret_cnt)
   );
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif

endmodule
`default_nettype wire

// File: tb/tb_excp_redirect.sv
`default_nettype none
// ============================================================================
// tb_excp_redirect : directed stimulus with a handshake scoreboard
// Revision: 1.0
// ============================================================================
module tb_excp_redirect;

   logic        clk = 1'b0;
   logic        resetn;
   logic        is_intexc;
   logic [31:0] entrance;
   logic        is_eret;
   logic [31:0] epc;
   logic        fetch_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_kind;
   logic        flush;
   logic        commit_block;
`ifdef EXCP_REDIRECT_STAT_EN
   logic [31:0] exc_cnt;
   logic [31:0] eret_cnt;
   logic [31:0] exc_base;
   logic [31:0] eret_base;
`endif

   int tests = 0;
   int fails = 0;
   logic [32:0] exp_q[$];

   always #5 clk = ~clk;

   excp_redirect #(.ADDR_W(32)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .is_intexc      (is_intexc),
      .entrance       (entrance),
      .is_eret        (is_eret),
      .epc            (epc),
      .fetch_ready    (fetch_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .redirect_kind  (redirect_kind),
      .flush          (flush),
`ifdef EXCP_REDIRECT_STAT_EN
      .exc_cnt        (exc_cnt),
      .eret_cnt       (eret_cnt),
`endif
      .commit_block   (commit_block)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string name);
      check({name, "_valid"}, {63'd0, redirect_valid}, 64'd0);
      check({name, "_flush"}, {63'd0, flush}, 64'd0);
      check({name, "_cblk"},  {63'd0, commit_block}, 64'd0);
   endtask

   // Monitor: every accepted handshake must match the next expected request.
   always @(negedge clk) begin
      if (resetn === 1'b1 && redirect_valid === 1'b1 && fetch_ready === 1'b1) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_handshake: got pc=%0h kind=%0b expected none",
                     redirect_pc, redirect_kind);
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            if ({redirect_pc, redirect_kind} !== e) begin
               fails++;
               $display("FAIL handshake: got pc=%0h kind=%0b expected pc=%0h kind=%0b",
                        redirect_pc, redirect_kind, e[32:1], e[0]);
            end
         end
      end
   end

   initial begin
      resetn = 1'b0; is_intexc = 1'b0; entrance = '0; is_eret = 1'b0;
      epc = '0; fetch_ready = 1'b0;
      #3;
      check("rst_valid", {63'd0, redirect_valid}, 64'd0);
      check("rst_pc",    {32'd0, redirect_pc}, 64'd0);
      check("rst_kind",  {63'd0, redirect_kind}, 64'd0);
      check("rst_cblk",  {63'd0, commit_block}, 64'd0);
      is_eret = 1'b1; #1;
      check("rst_flush_follows_req", {63'd0, flush}, 64'd1);
      is_eret = 1'b0; #1;
      check("rst_flush_low", {63'd0, flush}, 64'd0);
`ifdef EXCP_REDIRECT_STAT_EN
      check("rst_exc_cnt",  {32'd0, exc_cnt}, 64'd0);
      check("rst_eret_cnt", {32'd0, eret_cnt}, 64'd0);
`endif
      tick(); tick();
      resetn = 1'b1;
      tick();
      check_idle("idle0");

      // Exception accepted at first opportunity
      is_intexc = 1'b1; entrance = 32'hBFC00380; fetch_ready = 1'b1;
      exp_q.push_back({32'hBFC00380, 1'b0});
      #1;
      check("exc_flush_same_cycle", {63'd0, flush}, 64'd1);
      check("exc_valid_not_yet", {63'd0, redirect_valid}, 64'd0);
      tick();
      is_intexc = 1'b0;
      #1;
      check("exc_valid", {63'd0, redirect_valid}, 64'd1);
      check("exc_pc", {32'd0, redirect_pc}, {32'd0, 32'hBFC00380});
      check("exc_kind", {63'd0, redirect_kind}, 64'd0);
      check("exc_cblk", {63'd0, commit_block}, 64'd1);
      tick();
      check_idle("exc_done");

      // Eret with 3 stall cycles
      is_eret = 1'b1; epc = 32'h80001000; fetch_ready = 1'b0;
      exp_q.push_back({32'h80001000, 1'b1});
      tick();
      is_eret = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_valid", {63'd0, redirect_valid}, 64'd1);
         check("stall_flush", {63'd0, flush}, 64'd1);
         check("stall_cblk",  {63'd0, commit_block}, 64'd1);
         check("stall_pc", {32'd0, redirect_pc}, {32'd0, 32'h80001000});
         check("stall_kind", {63'd0, redirect_kind}, 64'd1);
         tick();
      end
      fetch_ready = 1'b1;
      tick();
      fetch_ready = 1'b0;
      check_idle("eret_done");

`ifdef EXCP_REDIRECT_STAT_EN
      exc_base = exc_cnt; eret_base = eret_cnt;
      check("cnt_after_two_exc",  {32'd0, exc_base}, 64'd1);
      check("cnt_after_two_eret", {32'd0, eret_base}, 64'd1);
`endif
      // Simultaneous events: exception wins
      is_intexc = 1'b1; is_eret = 1'b1; entrance = 32'hBFC00380; epc = 32'h80001000;
      fetch_ready = 1'b1;
      exp_q.push_back({32'hBFC00380, 1'b0});
      tick();
      is_intexc = 1'b0; is_eret = 1'b0;
      check("simul_pc", {32'd0, redirect_pc}, {32'd0, 32'hBFC00380});
      check("simul_kind", {63'd0, redirect_kind}, 64'd0);
      tick();
      fetch_ready = 1'b0;
      check_idle("simul_done");
`ifdef EXCP_REDIRECT_STAT_EN
      check("simul_eret_cnt", {32'd0, eret_cnt}, {32'd0, eret_base});
      check("simul_exc_cnt", {32'd0, exc_cnt}, {32'd0, exc_base + 32'd1});
      exc_base = exc_cnt; eret_base = eret_cnt;
`endif

      // Overwrite while pending
      is_eret = 1'b1; epc = 32'h80001000;
      tick();
      is_eret = 1'b0;
      check("ovw_pre_pc", {32'd0, redirect_pc}, {32'd0, 32'h80001000});
      check("ovw_pre_kind", {63'd0, redirect_kind}, 64'd1);
      is_intexc = 1'b1; entrance = 32'hBFC00200;
      tick();
      is_intexc = 1'b0;
      check("ovw_pc", {32'd0, redirect_pc}, {32'd0, 32'hBFC00200});
      check("ovw_kind", {63'd0, redirect_kind}, 64'd0);
      exp_q.push_back({32'hBFC00200, 1'b0});
      fetch_ready = 1'b1;
      tick();
      fetch_ready = 1'b0;
      check_idle("ovw_done");
`ifdef EXCP_REDIRECT_STAT_EN
      check("ovw_exc_cnt", {32'd0, exc_cnt - exc_base}, 64'd1);
      check("ovw_eret_cnt", {32'd0, eret_cnt - eret_base}, 64'd0);
`endif

      // Back-to-back: exception in the accept cycle, no bubble
      is_intexc = 1'b1; entrance = 32'hBFC00380; fetch_ready = 1'b1;
      exp_q.push_back({32'hBFC00380, 1'b0});
      tick();
      entrance = 32'hBFC00180;
      exp_q.push_back({32'hBFC00180, 1'b0});
      tick();
      is_intexc = 1'b0;
      check("b2b_valid", {63'd0, redirect_valid}, 64'd1);
      check("b2b_pc", {32'd0, redirect_pc}, {32'd0, 32'hBFC00180});
      tick();
      fetch_ready = 1'b0;
      check_idle("b2b_done");

      // Asynchronous reset while pending
      is_eret = 1'b1; epc = 32'h80002000;
      tick();
      is_eret = 1'b0;
      check("rstp_valid_before", {63'd0, redirect_valid}, 64'd1);
      #2 resetn = 1'b0;
      #1;
      check("rstp_valid", {63'd0, redirect_valid}, 64'd0);
      check("rstp_cblk", {63'd0, commit_block}, 64'd0);
      check("rstp_pc", {32'd0, redirect_pc}, 64'd0);
      check("rstp_kind", {63'd0, redirect_kind}, 64'd0);
      tick(); tick();
      resetn = 1'b1;
      fetch_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rstp_no_redirect", {63'd0, redirect_valid}, 64'd0);
      end
      fetch_ready = 1'b0;

`ifdef EXCP_REDIRECT_STAT_EN
      // Saturation
      @(posedge clk);
      #1 force dut.u_exc_cnt.value = 32'hFFFFFFFE;
      #1 release dut.u_exc_cnt.value;
      fetch_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         is_intexc = 1'b1; entrance = 32'hBFC00380;
         exp_q.push_back({32'hBFC00380, 1'b0});
         tick();
         is_intexc = 1'b0;
         tick();
      end
      fetch_ready = 1'b0;
      check("sat_exc_cnt", {32'd0, exc_cnt}, {32'd0, 32'hFFFFFFFF});
`endif

      // Drain scoreboard with a bounded wait
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/excp_redirect.md
# excp_redirect

Front-end redirect controller directly downstream of the CP0 block. It captures the CP0 "exception/interrupt taken" and "eret committed" events with their target addresses (exception entrance, EPC). It holds a single registered redirect request toward fetch under a valid/ready handshake until fetch accepts it. While the request is outstanding it kills younger pipeline work and blocks further commits.

## Interface
Parameters:
- `ADDR_W`, default 32: width of PC/target addresses.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous reset, active-low.
- `is_intexc`  in  `ADDR_W`-independent 1  CP0 takes an exception or interrupt this cycle.
- `entrance`  in  `ADDR_W`  exception vector from CP0; valid when `is_intexc`=1.
- `is_eret`  in  1  eret commits this cycle.
- `epc`  in  `ADDR_W`  CP0 EPC; valid when `is_eret`=1.
- `fetch_ready`  in  1  fetch stage accepts a redirect this cycle.
- `redirect_valid`  out  1  redirect request outstanding.
- `redirect_pc`  out  `ADDR_W`  redirect target.
- `redirect_kind`  out  1  0 = exception/interrupt, 1 = eret.
- `flush`  out  1  kill all stages younger than memory.
- `commit_block`  out  1  suppress memory-stage commit and CP0 writes.
- `exc_cnt`  out  32  exception redirects issued; present only with `EXCP_REDIRECT_STAT_EN`.
- `eret_cnt`  out  32  eret redirects issued; present only with `EXCP_REDIRECT_STAT_EN`.

## Operation
- There are two states.
  - **IDLE**: no request is outstanding.
  - **PEND**: the request register is valid.
- `req` = `is_intexc` | `is_eret`.
  - The target is `entrance` if `is_intexc`=1, else `epc`.
  - The kind is `is_intexc` ? 0 : 1.
  - When both inputs are high, the exception wins and the eret is dropped.
- **In IDLE:**
  - If `req`=1, load `redirect_pc`/`redirect_kind` and go to PEND.
  - Otherwise stay in IDLE.
- **In PEND with `fetch_ready`=1:** the handshake completes.
  - If `is_intexc`=1 in the same cycle, reload with the new exception target and stay in PEND.
  - Otherwise go to IDLE.
- **In PEND with `fetch_ready`=0:**
  - If `is_intexc`=1, overwrite the target and set kind=0. The pending request is replaced, not queued.
  - `is_eret` is ignored.
- `redirect_valid` = (state==PEND). It is registered.
- `flush` = `req` | (state==PEND). It is combinational, so the kill takes effect in the same cycle as the CP0 event.
- `commit_block` = (state==PEND). It is registered.
- `redirect_pc` is forwarded unmodified. There is no alignment check; misaligned targets are fetch's responsibility.

## Timing
- **Reset values:** state=IDLE, `redirect_valid`=0, `redirect_pc`=0, `redirect_kind`=0, `commit_block`=0. `flush` follows `req` combinationally. Counters are 0.
- **Reset assertion mid-PEND:** the request is discarded immediately, asynchronously. No redirect is issued after release.
- **Latency:** event in cycle N → `redirect_valid`=1 from N+1.
  - If fetch is ready in cycle N+1, the request is accepted in N+1 and the block is back in IDLE at N+2.
  - Minimum occupancy is 1 cycle.
- **Handshake:** transfer occurs when `redirect_valid` & `fetch_ready`. While `redirect_valid`=1 and `fetch_ready`=0, `redirect_pc` and `redirect_kind` are stable unless `is_intexc` overwrites them.
- **Back-to-back:** an exception arriving in the accept cycle does not insert an IDLE bubble.

## Configuration
- `EXCP_REDIRECT_STAT_EN` defined:
  - Adds `exc_cnt` and `eret_cnt`.
  - Each counter increments by 1 on every accepted handshake of its kind.
  - Each counter saturates at 32'hFFFFFFFF.
  - Overwritten (replaced) requests are not counted.
- `EXCP_REDIRECT_STAT_EN` undefined: the ports and counter logic are absent. The rest of the behaviour is identical.

## Structure
- Shared package holds:
  - `redirect_state_t` (IDLE, PEND).
  - `redirect_kind_t` (`RK_EXC`=0, `RK_ERET`=1).
  - A packed `redirect_req_t` {pc, kind}, reused by the fetch stage.
- One sub-module, `sat_counter`: a 32-bit saturating counter with increment enable, instantiated twice under the macro.

## Test plan
- **Exception:** reset → `is_intexc`=1, `entrance`=32'hBFC00380 with `fetch_ready`=1 → `flush`=1 the same cycle; next cycle `redirect_valid`=1, `redirect_pc`=32'hBFC00380, `redirect_kind`=0; back to IDLE after.
- **Eret with fetch stall:** `is_eret`=1, `epc`=32'h80001000, `fetch_ready`=0 for 3 cycles → `redirect_valid`, `flush` and `commit_block` all held high with a stable PC; accepted on the 4th cycle.
- **Simultaneous events:** `is_intexc` and `is_eret` high together with `entrance`=32'hBFC00380, `epc`=32'h80001000 → `redirect_pc`=32'hBFC00380, kind=0, and with the macro, `eret_cnt` unchanged.
- **Overwrite while pending:** PEND with eret target 32'h80001000 and `fetch_ready`=0, then `is_intexc`=1 with target 32'hBFC00200 → next cycle `redirect_pc`=32'hBFC00200, kind=0; a single handshake, `exc_cnt`=1, `eret_cnt`=0.
- **Reset mid-PEND:** deassert `resetn` while `redirect_valid`=1 → outputs go to 0 without waiting for a clock edge; after release, no redirect is issued.
- **Saturation (macro on):** force `exc_cnt` to 32'hFFFFFFFE, then run 3 accepted exceptions → `exc_cnt`=32'hFFFFFFFF.
